// File: rtl/demux_1x4_3bits_reg.sv
// ---------------------------------------------------------------------------
// demux_1x4_3bits_reg
//   Registered 1-to-4 demultiplexer. A WIDTH-bit word is steered either by
//   the explicit select {s1,s0} or by an internal round-robin pointer into one
//   of four holding registers. Each channel tracks full / overrun status so
//   consumers can drain channels independently with a per-channel ack.
//
// Ports
//   clk       in   rising-edge clock
//   reset     in   asynchronous active-high reset (clears data and control)
//   d         in   WIDTH  data word to distribute
//   d_valid   in   d is presented this cycle
//   s0, s1    in   manual select LSB / MSB
//   auto      in   1 = round-robin pointer selects, 0 = {s1,s0} selects
//   ack       in   4      ack[i] releases channel i
//   clr_ovr   in   clears all overrun flags (and the drop counter)
//   m0..m3    out  WIDTH  channel holding registers
//   full      out  4      channel holds unconsumed data
//   ovr       out  4      sticky overrun flag per channel
//   f0, f1    out  effective destination index LSB / MSB
//   ready     out  current destination can accept d this cycle
//   ovr_cnt   out  4      saturating dropped-write count
//                         (only when DEMUX_OVR_COUNT_EN is defined)
//
// Build option
//   DEMUX_OVR_COUNT_EN : adds the ovr_cnt port and its counter.
// ---------------------------------------------------------------------------
module demux_1x4_3bits_reg #(
  parameter int WIDTH = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  input  logic             d_valid,
  input  logic             s0,
  input  logic             s1,
  input  logic             auto,
  input  logic [3:0]       ack,
  input  logic             clr_ovr,
  output logic [WIDTH-1:0] m0,
  output logic [WIDTH-1:0] m1,
  output logic [WIDTH-1:0] m2,
  output logic [WIDTH-1:0] m3,
  output logic [3:0]       full,
  output logic [3:0]       ovr,
  output logic             f0,
  output logic             f1,
  output logic             ready
`ifdef DEMUX_OVR_COUNT_EN
  ,
  output logic [3:0]       ovr_cnt
`endif
);

  logic [WIDTH-1:0] r_m [4];
  logic [3:0]       r_full;
  logic [3:0]       r_ovr;
  logic [1:0]       r_ptr;

  logic [1:0]       w_dest;
  logic             w_ready;
  logic             w_wr;
  logic             w_drop;

  // Select lines are used live; nothing is latched from {s1,s0}.
  assign w_dest  = auto ? r_ptr : {s1, s0};
  // An ack on the destination frees the slot in the same cycle, so a
  // write-with-ack to a full channel is accepted rather than dropped.
  assign w_ready = ~r_full[w_dest] | ack[w_dest];
  assign w_wr    = d_valid & w_ready;
  assign w_drop  = d_valid & ~w_ready;

  assign f0    = w_dest[0];
  assign f1    = w_dest[1];
  assign ready = w_ready;

  assign m0   = r_m[0];
  assign m1   = r_m[1];
  assign m2   = r_m[2];
  assign m3   = r_m[3];
  assign full = r_full;
  assign ovr  = r_ovr;

  // Channel registers, status flags and pointer
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 4; i++) r_m[i] <= '0;
      r_full <= '0;
      r_ovr  <= '0;
      r_ptr  <= '0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (w_wr && (w_dest == 2'(i))) begin
          r_m[i]    <= d;
          r_full[i] <= 1'b1;     // a same-edge write beats the ack
        end else if (ack[i]) begin
          r_full[i] <= 1'b0;
        end

        if (w_drop && (w_dest == 2'(i)))
          r_ovr[i] <= 1'b1;      // a same-edge drop beats clr_ovr
        else if (clr_ovr)
          r_ovr[i] <= 1'b0;
      end

      if (auto && w_wr)
        r_ptr <= r_ptr + 2'd1;
    end
  end

`ifdef DEMUX_OVR_COUNT_EN
  logic [3:0] r_ovr_cnt;

  function automatic logic [3:0] sat_inc4(input logic [3:0] c);
    return (c == 4'hF) ? c : c + 4'd1;
  endfunction

  // Dropped-write counter
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      r_ovr_cnt <= '0;
    else if (clr_ovr)
      r_ovr_cnt <= w_drop ? 4'd1 : 4'd0;
    else if (w_drop)
      r_ovr_cnt <= sat_inc4(r_ovr_cnt);
  end

  assign ovr_cnt = r_ovr_cnt;
`endif

endmodule

// File: tb/tb_demux_1x4_3bits_reg.sv
module tb_demux_1x4_3bits_reg;

  logic       clk;
  logic       reset;
  logic [2:0] d;
  logic       d_valid;
  logic       s0, s1;
  logic       auto;
  logic [3:0] ack;
  logic       clr_ovr;
  logic [2:0] m0, m1, m2, m3;
  logic [3:0] full, ovr;
  logic       f0, f1, ready;
`ifdef DEMUX_OVR_COUNT_EN
  logic [3:0] ovr_cnt;
`endif

  int total = 0;
  int bad   = 0;

  demux_1x4_3bits_reg #(.WIDTH(3)) dut (
    .clk     (clk),
    .reset   (reset),
    .d       (d),
    .d_valid (d_valid),
    .s0      (s0),
    .s1      (s1),
    .auto    (auto),
    .ack     (ack),
    .clr_ovr (clr_ovr),
    .m0      (m0),
    .m1      (m1),
    .m2      (m2),
    .m3      (m3),
    .full    (full),
    .ovr     (ovr),
    .f0      (f0),
    .f1      (f1),
    .ready   (ready)
`ifdef DEMUX_OVR_COUNT_EN
    ,
    .ovr_cnt (ovr_cnt)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic       dv;
    logic [2:0] dd;
    logic       au;
    logic [1:0] sel;
    logic [3:0] ak;
    logic       clr;
    logic       e_rdy;   // combinational, before the edge
    logic [1:0] e_f;     // combinational, before the edge
    logic [2:0] e_m0, e_m1, e_m2, e_m3;  // after the edge
    logic [3:0] e_full, e_ovr;           // after the edge
  } vec_t;

  vec_t vec [21];

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic chk_state(input string p, input logic [2:0] a0, input logic [2:0] a1,
                           input logic [2:0] a2, input logic [2:0] a3,
                           input logic [3:0] fl, input logic [3:0] ov);
    chk({p, "_m0"},   8'(m0),   8'(a0));
    chk({p, "_m1"},   8'(m1),   8'(a1));
    chk({p, "_m2"},   8'(m2),   8'(a2));
    chk({p, "_m3"},   8'(m3),   8'(a3));
    chk({p, "_full"}, 8'(full), 8'(fl));
    chk({p, "_ovr"},  8'(ovr),  8'(ov));
  endtask

  task automatic idle_inputs();
    d = 3'd0; d_valid = 1'b0; ack = 4'h0; clr_ovr = 1'b0;
  endtask

  initial begin
    //        dv  d    au  sel   ack    clr   rdy  f     m0   m1   m2   m3   full     ovr
    vec[0]  = '{1'b1,3'd5,1'b0,2'd2,4'b0000,1'b0, 1'b1,2'd2, 3'd0,3'd0,3'd5,3'd0,4'b0100,4'b0000};
    vec[1]  = '{1'b0,3'd0,1'b0,2'd2,4'b0000,1'b0, 1'b0,2'd2, 3'd0,3'd0,3'd5,3'd0,4'b0100,4'b0000};
    vec[2]  = '{1'b0,3'd0,1'b0,2'd2,4'b0100,1'b0, 1'b1,2'd2, 3'd0,3'd0,3'd5,3'd0,4'b0000,4'b0000};
    vec[3]  = '{1'b1,3'd1,1'b1,2'd0,4'b0000,1'b0, 1'b1,2'd0, 3'd1,3'd0,3'd5,3'd0,4'b0001,4'b0000};
    vec[4]  = '{1'b1,3'd2,1'b1,2'd0,4'b0000,1'b0, 1'b1,2'd1, 3'd1,3'd2,3'd5,3'd0,4'b0011,4'b0000};
    vec[5]  = '{1'b1,3'd3,1'b1,2'd0,4'b0000,1'b0, 1'b1,2'd2, 3'd1,3'd2,3'd3,3'd0,4'b0111,4'b0000};
    vec[6]  = '{1'b1,3'd4,1'b1,2'd0,4'b0000,1'b0, 1'b1,2'd3, 3'd1,3'd2,3'd3,3'd4,4'b1111,4'b0000};
    vec[7]  = '{1'b1,3'd5,1'b1,2'd0,4'b0000,1'b0, 1'b0,2'd0, 3'd1,3'd2,3'd3,3'd4,4'b1111,4'b0001};
    vec[8]  = '{1'b0,3'd0,1'b1,2'd0,4'b0000,1'b0, 1'b0,2'd0, 3'd1,3'd2,3'd3,3'd4,4'b1111,4'b0001};
    vec[9]  = '{1'b1,3'd7,1'b0,2'd1,4'b0010,1'b0, 1'b1,2'd1, 3'd1,3'd7,3'd3,3'd4,4'b1111,4'b0001};
    vec[10] = '{1'b1,3'd6,1'b0,2'd1,4'b0000,1'b0, 1'b0,2'd1, 3'd1,3'd7,3'd3,3'd4,4'b1111,4'b0011};
    vec[11] = '{1'b0,3'd0,1'b0,2'd0,4'b0000,1'b1, 1'b0,2'd0, 3'd1,3'd7,3'd3,3'd4,4'b1111,4'b0000};
    vec[12] = '{1'b1,3'd2,1'b0,2'd0,4'b0000,1'b0, 1'b0,2'd0, 3'd1,3'd7,3'd3,3'd4,4'b1111,4'b0001};
    vec[13] = '{1'b1,3'd2,1'b0,2'd3,4'b0000,1'b1, 1'b0,2'd3, 3'd1,3'd7,3'd3,3'd4,4'b1111,4'b1000};
    vec[14] = '{1'b0,3'd0,1'b0,2'd0,4'b0101,1'b0, 1'b1,2'd0, 3'd1,3'd7,3'd3,3'd4,4'b1010,4'b1000};
    vec[15] = '{1'b0,3'd0,1'b0,2'd0,4'b0001,1'b0, 1'b1,2'd0, 3'd1,3'd7,3'd3,3'd4,4'b1010,4'b1000};
    vec[16] = '{1'b1,3'd3,1'b1,2'd0,4'b0000,1'b0, 1'b1,2'd0, 3'd3,3'd7,3'd3,3'd4,4'b1011,4'b1000};
    vec[17] = '{1'b0,3'd0,1'b0,2'd3,4'b0000,1'b0, 1'b0,2'd3, 3'd3,3'd7,3'd3,3'd4,4'b1011,4'b1000};
    vec[18] = '{1'b0,3'd0,1'b1,2'd3,4'b0000,1'b0, 1'b0,2'd1, 3'd3,3'd7,3'd3,3'd4,4'b1011,4'b1000};
    vec[19] = '{1'b1,3'd6,1'b1,2'd3,4'b0010,1'b0, 1'b1,2'd1, 3'd3,3'd6,3'd3,3'd4,4'b1011,4'b1000};
    vec[20] = '{1'b1,3'd5,1'b1,2'd3,4'b0000,1'b0, 1'b1,2'd2, 3'd3,3'd6,3'd5,3'd4,4'b1111,4'b1000};

    idle_inputs();
    auto = 1'b1; s0 = 1'b0; s1 = 1'b0;
    reset = 1'b1;

    // reset state
    @(negedge clk); #1;
    chk_state("rst", 3'd0, 3'd0, 3'd0, 3'd0, 4'h0, 4'h0);
    chk("rst_f",     8'({f1, f0}), 8'd0);
    chk("rst_ready", 8'(ready),    8'd1);
    @(negedge clk);
    reset = 1'b0;

    // table-driven vectors
    for (int i = 0; i < 21; i++) begin
      @(negedge clk);
      d_valid = vec[i].dv;  d = vec[i].dd;  auto = vec[i].au;
      {s1, s0} = vec[i].sel; ack = vec[i].ak; clr_ovr = vec[i].clr;
      #1;
      chk($sformatf("v%0d_ready", i), 8'(ready),    8'(vec[i].e_rdy));
      chk($sformatf("v%0d_f", i),     8'({f1, f0}), 8'(vec[i].e_f));
      @(posedge clk); #1;
      chk_state($sformatf("v%0d", i), vec[i].e_m0, vec[i].e_m1, vec[i].e_m2,
                vec[i].e_m3, vec[i].e_full, vec[i].e_ovr);
    end

    // mid-stream asynchronous reset
    @(negedge clk);
    idle_inputs();
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0; auto = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      d_valid = 1'b1; d = 3'(k);
      @(negedge clk);
    end
    d_valid = 1'b0;
    #1;
    chk("ms_full_pre", 8'(full),     8'b0111);
    chk("ms_f_pre",    8'({f1, f0}), 8'd3);
    #1 reset = 1'b1;
    #1;
    chk_state("ms_async", 3'd0, 3'd0, 3'd0, 3'd0, 4'h0, 4'h0);
    chk("ms_async_f", 8'({f1, f0}), 8'd0);
    @(negedge clk);
    reset = 1'b0;

`ifdef DEMUX_OVR_COUNT_EN
    // saturating drop counter
    auto = 1'b0; {s1, s0} = 2'd0;
    d_valid = 1'b1; d = 3'd7;
    @(negedge clk);
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (k == 0) chk("cnt_first", 8'(ovr_cnt), 8'd1);
    end
    chk("cnt_sat", 8'(ovr_cnt), 8'd15);
    d_valid = 1'b0; clr_ovr = 1'b1;
    @(negedge clk);
    chk("cnt_clr", 8'(ovr_cnt), 8'd0);
    d_valid = 1'b1;
    @(negedge clk);
    chk("cnt_clr_drop", 8'(ovr_cnt), 8'd1);
    idle_inputs();
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
